// File: rtl/dmem_arbiter.sv
// Arbiter sharing the 256x8 data memory between the core MEM stage and a DMA/debug port.
// Optional build macro DMEM_ARB_RR_EN selects 2-way round-robin in place of fixed core priority plus starvation guard.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_e;

  localparam logic [3:0] LOCK_MAX4 = 4'(LOCK_MAX);

  state_e     state_q, state_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_tag_q, rd_tag_d;
  logic       core_win, dma_win;

`ifdef DMEM_ARB_RR_EN
  logic       last_winner_q, last_winner_d;
`else
  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  // Arbitration and lock FSM
  always_comb begin
    core_win   = 1'b0;
    dma_win    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_ARB: begin
`ifdef DMEM_ARB_RR_EN
        if (core_req && dma_req) begin
          if (last_winner_q) core_win = 1'b1;
          else               dma_win  = 1'b1;
        end else if (core_req) begin
          core_win = 1'b1;
        end else if (dma_req) begin
          dma_win = 1'b1;
        end
`else
        if (dma_req && (starve_cnt_q == STARVE_LIM4)) begin
          dma_win = 1'b1;
        end else if (core_req) begin
          core_win = 1'b1;
        end else if (dma_req) begin
          dma_win = 1'b1;
        end
`endif
        if (dma_win && dma_lock && (LOCK_MAX > 1)) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = 4'd1;
        end
      end
      ST_LOCKED: begin
        if (dma_req) begin
          dma_win    = 1'b1;
          lock_cnt_d = lock_cnt_q + 4'd1;
          if (!dma_lock || ((lock_cnt_q + 4'd1) == LOCK_MAX4)) begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
          end
        end else begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Every visible output is forced low while reset is held
  always_comb begin
    core_gnt    = core_win & ~reset;
    dma_gnt     = dma_win & ~reset;
    core_stall  = core_req & ~core_gnt & ~reset;
    mem_en      = core_gnt | dma_gnt;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
    core_rvalid = rd_pend_q & ~rd_tag_q & ~reset;
    dma_rvalid  = rd_pend_q & rd_tag_q & ~reset;
    core_rdata  = core_rvalid ? mem_rdata : '0;
    dma_rdata   = dma_rvalid ? mem_rdata : '0;
  end

  always_comb begin
    rd_pend_d = mem_en & ~mem_we;
    rd_tag_d  = dma_gnt;
`ifdef DMEM_ARB_RR_EN
    last_winner_d = last_winner_q;
    if (dma_gnt)       last_winner_d = 1'b1;
    else if (core_gnt) last_winner_d = 1'b0;
`else
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_gnt)          starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_LIM4) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= 1'b0;
`else
      starve_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= last_winner_d;
`else
      starve_cnt_q  <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed per-cycle vectors push expected responses, a negedge monitor compares.
module tb_dmem_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_stall, core_rvalid;
  logic [7:0] core_rdata;
  logic       dma_req, dma_we, dma_lock;
  logic [7:0] dma_addr, dma_wdata;
  logic       dma_gnt, dma_rvalid;
  logic [7:0] dma_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory; preloaded with the read-test values while reset is high
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 8'hA5;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic       cg, dg, st, men, mwe;
    logic [7:0] madr, mwd;
    logic       crv;
    logic [7:0] crd;
    logic       drv;
    logic [7:0] drd;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("core_gnt",    8'(core_gnt),    8'(e.cg));
      chk("dma_gnt",     8'(dma_gnt),     8'(e.dg));
      chk("core_stall",  8'(core_stall),  8'(e.st));
      chk("mem_en",      8'(mem_en),      8'(e.men));
      chk("mem_we",      8'(mem_we),      8'(e.mwe));
      chk("mem_addr",    mem_addr,        e.madr);
      chk("mem_wdata",   mem_wdata,       e.mwd);
      chk("core_rvalid", 8'(core_rvalid), 8'(e.crv));
      chk("core_rdata",  core_rdata,      e.crd);
      chk("dma_rvalid",  8'(dma_rvalid),  8'(e.drv));
      chk("dma_rdata",   dma_rdata,       e.drd);
    end
  end

  // One cycle of stimulus with hand-computed grant and read-return expectations
  task automatic step(input logic rst,
                      input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cwd,
                      input logic dr, input logic dwe, input logic dl, input logic [7:0] da, input logic [7:0] dwd,
                      input logic ecg, input logic edg,
                      input logic ecrv, input logic [7:0] ecrd,
                      input logic edrv, input logic [7:0] edrd);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    core_req = cr;  core_we = cwe;  core_addr = ca;  core_wdata = cwd;
    dma_req = dr;   dma_we = dwe;   dma_lock = dl;   dma_addr = da;   dma_wdata = dwd;
    e.cg   = ecg;
    e.dg   = edg;
    e.st   = cr & ~ecg & ~rst;
    e.men  = ecg | edg;
    e.mwe  = ecg ? cwe : (edg ? dwe : 1'b0);
    e.madr = ecg ? ca  : (edg ? da  : 8'h00);
    e.mwd  = ecg ? cwd : (edg ? dwd : 8'h00);
    e.crv  = ecrv;
    e.crd  = ecrd;
    e.drv  = edrv;
    e.drd  = edrd;
    expq.push_back(e);
  endtask

  task automatic idle(input logic ecrv, input logic [7:0] ecrd, input logic edrv, input logic [7:0] edrd);
    step(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0, ecrv,ecrd, edrv,edrd);
  endtask

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0;  dma_we = 0;  dma_lock = 0;  dma_addr = '0;  dma_wdata = '0;

    // Reset holds all outputs low even with both requesting
    step(1, 1,0,8'h10,8'h00, 1,0,0,8'h02,8'h00, 0,0, 0,8'h00, 0,8'h00);
    step(1, 1,1,8'h40,8'h01, 1,1,0,8'h41,8'h77, 0,0, 0,8'h00, 0,8'h00);

`ifdef DMEM_ARB_RR_EN
    // Round-robin: dma first since last_winner resets to core
    step(0, 1,1,8'h40,8'h01, 1,1,0,8'h41,8'h77, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h40,8'h01, 1,1,0,8'h41,8'h77, 1,0, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h40,8'h02, 1,1,0,8'h41,8'h78, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h40,8'h02, 1,1,0,8'h41,8'h78, 1,0, 0,8'h00, 0,8'h00);
    idle(0,8'h00, 0,8'h00);
`else
    // Contention: core wins four cycles, starvation guard forces dma on the fifth
    for (int i = 0; i < 4; i++)
      step(0, 1,1,8'h40,8'h01, 1,1,0,8'h41,8'h77, 1,0, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h40,8'h01, 1,1,0,8'h41,8'h77, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h40,8'h02, 1,1,0,8'h41,8'h78, 1,0, 0,8'h00, 0,8'h00);
    idle(0,8'h00, 0,8'h00);
`endif

    // Core read of 0x10 returns A5 one cycle later
    step(0, 1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 0,8'h00);
    idle(1,8'hA5, 0,8'h00);

    // Lock burst: dma owns four writes, core waits, then the burst resumes
    step(0, 0,0,8'h00,8'h00, 1,1,1,8'h20,8'hA0, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h50,8'h55, 1,1,1,8'h21,8'hA1, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h50,8'h55, 1,1,1,8'h22,8'hA2, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h50,8'h55, 1,1,1,8'h23,8'hA3, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h50,8'h55, 1,1,1,8'h24,8'hA4, 1,0, 0,8'h00, 0,8'h00);
    step(0, 0,0,8'h00,8'h00, 1,1,1,8'h24,8'hA4, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h51,8'h66, 1,1,0,8'h25,8'hA5, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,1,8'h51,8'h66, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 0,8'h00);

    // Interleaved reads route data to the right owner
    step(0, 1,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 0,8'h00);
    step(0, 0,0,8'h00,8'h00, 1,0,0,8'h02,8'h00, 0,1, 1,8'h11, 0,8'h00);
    step(0, 1,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 1,8'h22);
    step(0, 0,0,8'h00,8'h00, 1,0,0,8'h02,8'h00, 0,1, 1,8'h11, 0,8'h00);
    step(0, 1,0,8'h22,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 1,8'h22);
    idle(1,8'hA2, 0,8'h00);

    // Reset right after a dma read grant swallows its return
    step(0, 0,0,8'h00,8'h00, 1,0,0,8'h02,8'h00, 0,1, 0,8'h00, 0,8'h00);
    step(1, 1,0,8'h10,8'h00, 1,0,0,8'h02,8'h00, 0,0, 0,8'h00, 0,8'h00);
`ifdef DMEM_ARB_RR_EN
    step(0, 1,0,8'h10,8'h00, 1,0,0,8'h02,8'h00, 0,1, 0,8'h00, 0,8'h00);
    step(0, 1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0, 0,8'h00, 1,8'h22);
    idle(1,8'hA5, 0,8'h00);
`else
    step(0, 1,0,8'h10,8'h00, 1,0,0,8'h02,8'h00, 1,0, 0,8'h00, 0,8'h00);
    step(0, 0,0,8'h00,8'h00, 1,0,0,8'h02,8'h00, 0,1, 1,8'hA5, 0,8'h00);
    idle(0,8'h00, 1,8'h22);
`endif
    idle(0,8'h00, 0,8'h00);

    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
